// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: op-codes, FSM
// state encoding and a small one-hot helper for the two-requester ports.
package alu_pkg;

   // ALU op select. SUB and ADD each have an alias with bit 1 set, so
   // bit 2 selects the arithmetic group and bit 0 picks add over subtract.
   localparam logic [2:0] OP_AND     = 3'b000;
   localparam logic [2:0] OP_OR      = 3'b001;
   localparam logic [2:0] OP_XOR     = 3'b010;
   localparam logic [2:0] OP_NOT     = 3'b011;
   localparam logic [2:0] OP_SUB     = 3'b100;
   localparam logic [2:0] OP_ADD     = 3'b101;
   localparam logic [2:0] OP_SUB_ALT = 3'b110;
   localparam logic [2:0] OP_ADD_ALT = 3'b111;

   // Scheduler FSM encoding.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   typedef logic [1:0] req_vec_t;

   // Requester index to its bit in a two-wide handshake vector.
   function automatic req_vec_t onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_rr_sched_alu4.sv
// Purely combinational ALU datapath shared by both requesters.
// Arithmetic wraps modulo 2^WIDTH; carry and borrow are dropped.
module alu4
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // Op decode; the NOT case ignores b entirely.
   always_comb begin
      y = '0;
      case (op)
         OP_AND:             y = a & b;
         OP_OR:              y = a | b;
         OP_XOR:             y = a ^ b;
         OP_NOT:             y = ~a;
         OP_SUB, OP_SUB_ALT: y = a - b;
         OP_ADD, OP_ADD_ALT: y = a + b;
         default:            y = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters.
// One operation in flight at a time: accept in IDLE, compute in EXEC,
// hold the result in RESP until the issuing requester takes it.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | arbitrate; grant one valid requester, latch its operands
//   S_EXEC | latched operands drive the ALU; result registered into res
//   S_RESP | resp_valid[id] high with res on resp_data until resp_ready[id]
module alu_rr_sched
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [5:0]         req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [1:0]         resp_valid,
   input  logic [1:0]         resp_ready,
   output logic [WIDTH-1:0]   resp_data,
   output logic               busy,
   output logic [CNT_W-1:0]   op_count
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             last_grant;
   logic             id;
   logic             g;
   logic             accept;
   logic             resp_done;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] alu_y;
   logic [CNT_W-1:0] cnt;

   // Grant pick: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      g = 1'b0;
      case (req_valid)
         2'b10:   g = 1'b1;
         2'b11:   g = ~last_grant;
         default: g = 1'b0;
      endcase
   end

   // Ready only in IDLE and only outside reset, so nothing is accepted
   // on the edge that clears the FSM.
   always_comb begin
      req_ready = 2'b00;
      if (rst_n && (state == S_IDLE) && (req_valid != 2'b00))
         req_ready = onehot2(g);
   end

   assign accept    = |(req_valid & req_ready);
   assign resp_done = (state == S_RESP) && resp_ready[id];

   // Response side is presented only while RESP holds a result.
   always_comb begin
      resp_valid = 2'b00;
      if (rst_n && (state == S_RESP))
         resp_valid = onehot2(id);
   end

   assign resp_data = res;
   assign busy      = (state != S_IDLE);
   assign op_count  = cnt;

   // Next-state logic for the three-phase operation cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)    state_nxt = S_EXEC;
         S_EXEC:                 state_nxt = S_RESP;
         S_RESP:  if (resp_done) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // State register; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Operand capture at the request handshake; held for the whole operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_r <= '0;
         a_r  <= '0;
         b_r  <= '0;
         id   <= 1'b0;
      end else if (accept) begin
         op_r <= g ? req_op[5:3] : req_op[2:0];
         a_r  <= g ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
         b_r  <= g ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
         id   <= g;
      end
   end

   alu4 #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op (op_r),
      .a  (a_r),
      .b  (b_r),
      .y  (alu_y)
   );

   // Result register, loaded once per operation during EXEC.
   always_ff @(posedge clk) begin
      if (!rst_n)                res <= '0;
      else if (state == S_EXEC)  res <= alu_y;
   end

   // Round-robin history; updated only when a response is actually taken.
   // Reset value 1 lets requester 0 win the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n)         last_grant <= 1'b1;
      else if (resp_done) last_grant <= id;
   end

   // Completed-response counter, free-running modulo 2^CNT_W.
   always_ff @(posedge clk) begin
      if (!rst_n)         cnt <= '0;
      else if (resp_done) cnt <= cnt + 1'b1;
   end

endmodule
